// File: rtl/priRV32_uart_pkg.sv
// Shared types and helpers for the arbitrated UART transmitter.
package priRV32_uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_clks_per_bit(input int clock_mhz, input int baud);
    return (clock_mhz * 1000000 + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_done pulses on the last cycle of every bit period.
// The count is held at zero while restart is high, so it never free-runs in
// idle and always starts a fresh bit period on the cycle a frame begins.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  // Next count: clear on restart or at the end of a bit period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_done) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding an 8N1 UART transmitter.
// Optional even parity bit: define PRIRV32_UART_PARITY_EN.
module uart_tx_arbiter
  import priRV32_uart_pkg::*;
#(
  parameter int Clock = 50,
  parameter int Baud  = 115200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [UART_DATA_W-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [UART_DATA_W-1:0] req1_data,
  output logic                   req1_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   grant_id
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(Clock, Baud);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_arbiter: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  uart_tx_state_t         state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   grant_id_q, grant_id_d;
  logic                   last_grant_q, last_grant_d;
  logic                   busy_q, busy_d;
  logic                   tx_q, tx_d;
`ifdef PRIRV32_UART_PARITY_EN
  logic                   par_q, par_d;
`endif
  logic                   grant, accept, bit_done;

  // Only IDLE restarts the timer; every other state entry coincides with a
  // bit_done wrap, so the count is already zero there.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (state_q == IDLE),
    .bit_done (bit_done)
  );

  // Round-robin pick: contention goes to whoever did not win last time.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = !last_grant_q;
  end

  assign req0_ready = (state_q == IDLE) && !grant && req0_valid && !rst;
  assign req1_ready = (state_q == IDLE) &&  grant && req1_valid && !rst;
  assign accept     = req0_ready || req1_ready;

  // Frame sequencing; tx is computed for the next state so the pin is a flop.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    tx_d         = 1'b1;
`ifdef PRIRV32_UART_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = START;
          shreg_d      = grant ? req1_data : req0_data;
          bit_idx_d    = '0;
          grant_id_d   = grant;
          last_grant_d = grant;
          busy_d       = 1'b1;
`ifdef PRIRV32_UART_PARITY_EN
          par_d        = grant ? ^req1_data : ^req0_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_d   = {1'b0, shreg_q[UART_DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef PRIRV32_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PRIRV32_UART_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef PRIRV32_UART_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      tx_q         <= 1'b1;
`ifdef PRIRV32_UART_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      tx_q         <= tx_d;
`ifdef PRIRV32_UART_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter at 4 clocks per bit.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;
`ifdef PRIRV32_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, tx, busy, grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.Clock(1), .Baud(250000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  typedef struct packed { logic gid; logic [7:0] data; } exp_t;
  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  int   rdy0_cnt = 0, rdy1_cnt = 0, both_rdy = 0;
  logic mlast = 1'b1;

  always @(negedge clk) begin
    if (req0_ready === 1'b1) rdy0_cnt <= rdy0_cnt + 1;
    if (req1_ready === 1'b1) rdy1_cnt <= rdy1_cnt + 1;
    if (req0_ready === 1'b1 && req1_ready === 1'b1) both_rdy <= both_rdy + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference arbiter: record who should win and what byte goes out.
  task automatic model_push(input logic v0, input logic v1, input logic [7:0] d0, input logic [7:0] d1);
    logic g;
    g = (v0 && v1) ? !mlast : v1;
    sb.push_back('{gid: g, data: (g ? d1 : d0)});
    mlast = g;
  endtask

  function automatic logic [10:0] mk_pattern(input logic [7:0] d);
    logic [10:0] p;
    p = '0;
    p[8:1] = d;
    p[NB-1] = 1'b1;
    if (NB == 11) p[9] = ^d;
    return p;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mlast = 1'b1;
  endtask

  // Wait (bounded) for a start bit, then record one frame at negedges.
  task automatic capture_frame(output logic got, output int w, output logic [10:0] bits,
                               output logic uni, output int blen, output logic bend, output logic gid);
    logic [43:0] s;
    got = 1'b0; w = 0; bits = '0; uni = 1'b1; blen = 0; bend = 1'b1; gid = 1'b0; s = '0;
    @(negedge clk);
    while (tx !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    if (tx !== 1'b0) return;
    got = 1'b1;
    gid = grant_id;
    for (int i = 0; i < NB*CPB; i++) begin
      s[i] = tx;
      if (busy === 1'b1) blen++;
      @(negedge clk);
    end
    bend = busy;
    for (int k = 0; k < NB; k++) begin
      bits[k] = s[k*CPB];
      for (int j = 1; j < CPB; j++) if (s[k*CPB+j] !== s[k*CPB]) uni = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({tx, busy, grant_id, req0_ready, req1_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_values: got tx/busy/gid/rdy0/rdy1=%b want 10000",
               {tx, busy, grant_id, req0_ready, req1_ready});
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({tx, busy, req0_ready, req1_ready} !== 4'b1000) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: got tx/busy/rdy0/rdy1=%b want 1000", i,
                 {tx, busy, req0_ready, req1_ready});
      end
    end
  endtask

  task automatic test_single();
    logic got, uni, bend, gid; int w, blen, r0, r1; logic [10:0] bits; exp_t e;
    @(posedge clk); #1;
    req0_data = 8'hA5; req0_valid = 1'b1;
    model_push(1'b1, 1'b0, 8'hA5, 8'h00);
    r0 = rdy0_cnt; r1 = rdy1_cnt;
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_data = 8'hFF;
    capture_frame(got, w, bits, uni, blen, bend, gid);
    vectors++;
    if (!got || sb.size() == 0) begin
      miscompares++;
      $display("FAIL single_frame: got start=%0b queued=%0d want a frame", got, sb.size());
    end else begin
      e = sb.pop_front();
      vectors += 3;
      if ({gid, bits} !== {e.gid, mk_pattern(e.data)}) begin
        miscompares++;
        $display("FAIL single_bits: got gid=%0b bits=%b want gid=%0b bits=%b", gid, bits, e.gid, mk_pattern(e.data));
      end
      if (uni !== 1'b1) begin
        miscompares++;
        $display("FAIL single_bitwidth: got uniform=%0b want 1", uni);
      end
      if (blen !== NB*CPB || bend !== 1'b0) begin
        miscompares++;
        $display("FAIL single_busy: got len=%0d end=%0b want len=%0d end=0", blen, bend, NB*CPB);
      end
    end
    vectors++;
    if (rdy0_cnt - r0 !== 1 || rdy1_cnt - r1 !== 0) begin
      miscompares++;
      $display("FAIL single_ready: got rdy0=%0d rdy1=%0d want 1 0", rdy0_cnt - r0, rdy1_cnt - r1);
    end
  endtask

  // Both requesters held valid for n frames: checks order and one-cycle gap.
  task automatic run_contention(input string name, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic got, uni, bend, gid; int w, blen, r0, r1; logic [10:0] bits; exp_t e;
    do_reset();
    @(posedge clk); #1;
    req0_data = d0; req1_data = d1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int f = 0; f < n; f++) model_push(1'b1, 1'b1, d0, d1);
    r0 = rdy0_cnt; r1 = rdy1_cnt;
    for (int f = 0; f < n; f++) begin
      if (f == n-1)
        fork begin @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0; end join_none
      capture_frame(got, w, bits, uni, blen, bend, gid);
      vectors++;
      if (!got || sb.size() == 0) begin
        miscompares++;
        $display("FAIL %s_frame%0d: got start=%0b queued=%0d want a frame", name, f, got, sb.size());
      end else begin
        e = sb.pop_front();
        vectors += 2;
        if ({gid, bits} !== {e.gid, mk_pattern(e.data)}) begin
          miscompares++;
          $display("FAIL %s_frame%0d: got gid=%0b bits=%b want gid=%0b bits=%b", name, f, gid, bits, e.gid, mk_pattern(e.data));
        end
        if (uni !== 1'b1 || blen !== NB*CPB || bend !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_timing%0d: got uniform=%0b busylen=%0d end=%0b want 1 %0d 0", name, f, uni, blen, bend, NB*CPB);
        end
        if (f > 0) begin
          vectors++;
          if (w !== 0) begin
            miscompares++;
            $display("FAIL %s_gap%0d: got %0d extra idle cycles want 0", name, f, w);
          end
        end
      end
    end
    vectors++;
    if (rdy0_cnt - r0 !== (n+1)/2 || rdy1_cnt - r1 !== n/2) begin
      miscompares++;
      $display("FAIL %s_ready: got rdy0=%0d rdy1=%0d want %0d %0d", name, rdy0_cnt - r0, rdy1_cnt - r1, (n+1)/2, n/2);
    end
  endtask

  task automatic test_contention();
    run_contention("contention", 2, 8'h11, 8'h22);
  endtask

  task automatic test_back_to_back();
    run_contention("b2b", 4, 8'h5A, 8'hC3);
  endtask

  task automatic test_reset_midframe();
    logic got, uni, bend, gid; int w, blen; logic [10:0] bits; exp_t e;
    do_reset();
    @(posedge clk); #1;
    req0_data = 8'h96; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy: got busy=%0b want 1 before reset", busy);
    end
    req1_data = 8'h3C; req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({tx, busy, grant_id, req0_ready, req1_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL midframe_reset: got tx/busy/gid/rdy0/rdy1=%b want 10000",
               {tx, busy, grant_id, req0_ready, req1_ready});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mlast = 1'b1;
    model_push(1'b0, 1'b1, 8'h00, 8'h3C);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    capture_frame(got, w, bits, uni, blen, bend, gid);
    vectors++;
    if (!got || sb.size() == 0) begin
      miscompares++;
      $display("FAIL midframe_frame: got start=%0b queued=%0d want a frame", got, sb.size());
    end else begin
      e = sb.pop_front();
      vectors += 2;
      if ({gid, bits} !== {e.gid, mk_pattern(e.data)}) begin
        miscompares++;
        $display("FAIL midframe_bits: got gid=%0b bits=%b want gid=%0b bits=%b", gid, bits, e.gid, mk_pattern(e.data));
      end
      if (uni !== 1'b1 || blen !== NB*CPB || bend !== 1'b0) begin
        miscompares++;
        $display("FAIL midframe_timing: got uniform=%0b busylen=%0d end=%0b want 1 %0d 0", uni, blen, bend, NB*CPB);
      end
    end
  endtask

`ifdef PRIRV32_UART_PARITY_EN
  task automatic test_parity();
    logic got, uni, bend, gid; int w, blen; logic [10:0] bits; exp_t e;
    do_reset();
    @(posedge clk); #1;
    req1_data = 8'h07; req1_valid = 1'b1;
    model_push(1'b0, 1'b1, 8'h00, 8'h07);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    capture_frame(got, w, bits, uni, blen, bend, gid);
    vectors++;
    if (!got || sb.size() == 0) begin
      miscompares++;
      $display("FAIL parity_frame: got start=%0b queued=%0d want a frame", got, sb.size());
    end else begin
      e = sb.pop_front();
      vectors += 2;
      if ({gid, bits} !== {e.gid, mk_pattern(e.data)}) begin
        miscompares++;
        $display("FAIL parity_bits: got gid=%0b bits=%b want gid=%0b bits=%b", gid, bits, e.gid, mk_pattern(e.data));
      end
      if (uni !== 1'b1 || blen !== 44 || bend !== 1'b0) begin
        miscompares++;
        $display("FAIL parity_timing: got uniform=%0b busylen=%0d end=%0b want 1 44 0", uni, blen, bend);
      end
    end
  endtask
`endif

  task automatic test_final();
    vectors++;
    if (both_rdy !== 0 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL final_state: got both_ready=%0d leftover=%0d want 0 0", both_rdy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_midframe();
`ifdef PRIRV32_UART_PARITY_EN
    test_parity();
`endif
    test_final();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
